gray_binarize: RTL and testbench
================================

GRAY_BINARIZE -- requirements
Module: gray_binarize

Interface
REQ-001 SHALL provide: module_clk  input  1  single block clock; all logic rising-edge.
REQ-002 SHALL provide: module_rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL provide: cam_href  input  1  line-valid from camera capture.
REQ-004 SHALL provide: cam_vsync  input  1  frame sync; rising edge marks frame start.
REQ-005 SHALL provide: pix_val  input  1  gray pixel valid, one pixel per asserted cycle.
REQ-006 SHALL provide: pix_data  input  8  gray pixel value.
REQ-007 SHALL provide: thr  input  8  static threshold; sampled at each frame start.
REQ-008 SHALL provide: inv  input  1  0 = foreground is pix>thr, 1 = foreground is pix<=thr.
REQ-009 SHALL provide: bin_val  output  1  binary pixel valid (drives downstream din_val).
REQ-010 SHALL provide: bin_dout  output  1  binary pixel (drives downstream din).
REQ-011 SHALL provide: bin_href, bin_vsync  output  1 each  syncs delayed to align with bin_val.
REQ-012 SHALL provide: col_cnt  output  12  column index of current bin_dout, 0-based.
REQ-013 SHALL provide: line_cnt  output  12  line index of current bin_dout, 0-based.
REQ-014 SHALL provide: frame_done  output  1  one-cycle pulse at end of a completed frame.
REQ-015 SHALL provide parameter MAX_COLS, default 1280, max column count; extra pixels dropped.

Function
REQ-016 Latency SHALL be exactly 2 cycles from pix_val/pix_data to bin_val/bin_dout; bin_href/bin_vsync SHALL be delayed by the same 2 cycles.
REQ-017 FSM states SHALL be IDLE, WAIT_LINE, LINE.
REQ-018 IDLE -> WAIT_LINE on cam_vsync rising edge (edge detected from a one-cycle registered copy); before that bin_val SHALL stay 0.
REQ-019 WAIT_LINE -> LINE on cam_href rising edge; col_cnt SHALL clear to 0.
REQ-020 LINE -> WAIT_LINE on cam_href falling edge; line_cnt SHALL increment by 1 if at least one pixel was accepted in the line, saturating at 4095.
REQ-021 cam_vsync rising edge in any non-IDLE state SHALL restart: state WAIT_LINE, line_cnt = 0, col_cnt = 0; frame_done SHALL pulse if line_cnt was nonzero.
REQ-022 In LINE with pix_val=1 and col_cnt < MAX_COLS: bin_val=1, bin_dout = (pix_data > thr_latched) XOR inv, and col_cnt increments after the pixel.
REQ-023 pix_val outside LINE, or with col_cnt >= MAX_COLS, SHALL be ignored (bin_val=0, counters unchanged).
REQ-024 thr SHALL be latched into thr_latched on each frame-start edge; changes mid-frame SHALL take no effect until the next frame.
REQ-025 cam_href and cam_vsync rising on the same cycle SHALL be treated as frame start first, then line start (state LINE, line_cnt=0).

Reset
REQ-026 On module_rst_n=0: state IDLE, bin_val/bin_dout/bin_href/bin_vsync/frame_done = 0, col_cnt = line_cnt = 0, thr_latched = 8'd128, pipeline cleared.
REQ-027 Reset asserted mid-line SHALL abort the line; after release output SHALL resume only after the next cam_vsync rising edge.

Configuration
REQ-028 Macro BIN_AUTO_THR_EN defined: block SHALL track min/max pix_data of accepted pixels per frame and at frame start load thr_latched = (min+max)>>1 (9-bit sum) from the previous frame, using thr only for the first frame after reset; min/max reset to 255/0 each frame.
REQ-029 Macro BIN_AUTO_THR_EN undefined: no min/max logic; thr_latched is loaded from thr only.

Verification
REQ-030 Reset, vsync edge, href high, 4 pixels 10,200,128,129 with thr=128, inv=0 -> bin_dout 0,1,0,1 with bin_val high 2 cycles after each input; col_cnt 0..3.
REQ-031 Same stimulus with inv=1 -> bin_dout 1,0,1,0.
REQ-032 MAX_COLS=4, 6 pixels in one line -> exactly 4 bin_val pulses; line_cnt increments to 1 on href fall.
REQ-033 3 lines then new vsync edge -> frame_done one-cycle pulse, line_cnt returns 0; thr changed to 50 mid-frame applies only to next frame.
REQ-034 Reset pulse mid-line -> all outputs 0 immediately; pixels ignored until next vsync edge.
REQ-035 With BIN_AUTO_THR_EN: frame 1 pixels span 40..200 -> frame 2 uses threshold 120 (pixel 120 -> 0, 121 -> 1).

Source files
------------

// File: rtl/gray_binarize.sv
// Gray-to-binary thresholding with a two-stage output pipeline and line/column/frame tracking.
// Optional BIN_AUTO_THR_EN: each frame's threshold is the min/max midpoint of the previous frame.
module gray_binarize #(
    parameter int unsigned MAX_COLS = 1280
) (
    input  logic        module_clk,
    input  logic        module_rst_n,
    input  logic        cam_href,
    input  logic        cam_vsync,
    input  logic        pix_val,
    input  logic [7:0]  pix_data,
    input  logic [7:0]  thr,
    input  logic        inv,
    output logic        bin_val,
    output logic        bin_dout,
    output logic        bin_href,
    output logic        bin_vsync,
    output logic [11:0] col_cnt,
    output logic [11:0] line_cnt,
    output logic        frame_done
);

    localparam logic [11:0] MAX_C = 12'(MAX_COLS);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_LINE,
        LINE
    } state_t;

    state_t      state_q;
    logic        vsync_q;
    logic        href_q;
    logic [11:0] col_q;
    logic [11:0] line_q;
    logic        got_pix_q;
    logic [7:0]  thr_q;
    logic [7:0]  thr_d;

    logic        vs_rise;
    logic        href_rise;
    logic        href_fall;
    logic        accept;
    logic        fg_d;
    logic        fdone_d;

    logic        s1_val_q;
    logic        s1_dout_q;
    logic        s1_href_q;
    logic        s1_vsync_q;
    logic        s1_fdone_q;
    logic [11:0] s1_col_q;
    logic [11:0] s1_line_q;

    assign vs_rise   = cam_vsync & ~vsync_q;
    assign href_rise = cam_href & ~href_q;
    assign href_fall = ~cam_href & href_q;
    // A frame-start edge wins over a pixel presented in the same cycle.
    assign accept    = (state_q == LINE) && pix_val && !vs_rise && (col_q < MAX_C);
    assign fg_d      = accept & ((pix_data > thr_q) ^ inv);
    assign fdone_d   = vs_rise && (state_q != IDLE) && (line_q != '0);

`ifdef BIN_AUTO_THR_EN
    logic [7:0] min_q;
    logic [7:0] max_q;
    logic       first_q;
    logic [8:0] mid_sum;

    assign mid_sum = {1'b0, min_q} + {1'b0, max_q};
    assign thr_d   = first_q ? thr : mid_sum[8:1];

    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            min_q   <= 8'hFF;
            max_q   <= '0;
            first_q <= 1'b1;
        end else if (vs_rise) begin
            min_q   <= 8'hFF;
            max_q   <= '0;
            first_q <= 1'b0;
        end else if (accept) begin
            if (pix_data < min_q) min_q <= pix_data;
            if (pix_data > max_q) max_q <= pix_data;
        end
    end
`else
    assign thr_d = thr;
`endif

    // Edge detectors reset high so a sync already asserted at reset release is not taken as an edge.
    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            state_q   <= IDLE;
            vsync_q   <= 1'b1;
            href_q    <= 1'b1;
            col_q     <= '0;
            line_q    <= '0;
            got_pix_q <= 1'b0;
            thr_q     <= 8'd128;
        end else begin
            vsync_q <= cam_vsync;
            href_q  <= cam_href;
            if (vs_rise) begin
                thr_q     <= thr_d;
                line_q    <= '0;
                col_q     <= '0;
                got_pix_q <= 1'b0;
                state_q   <= href_rise ? LINE : WAIT_LINE;
            end else begin
                case (state_q)
                    IDLE: begin
                    end
                    WAIT_LINE: begin
                        if (href_rise) begin
                            state_q   <= LINE;
                            col_q     <= '0;
                            got_pix_q <= 1'b0;
                        end
                    end
                    LINE: begin
                        if (accept) begin
                            col_q     <= col_q + 12'd1;
                            got_pix_q <= 1'b1;
                        end
                        if (href_fall) begin
                            state_q <= WAIT_LINE;
                            if ((got_pix_q || accept) && (line_q != '1)) begin
                                line_q <= line_q + 12'd1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge module_clk or negedge module_rst_n) begin
        if (!module_rst_n) begin
            s1_val_q   <= 1'b0;
            s1_dout_q  <= 1'b0;
            s1_href_q  <= 1'b0;
            s1_vsync_q <= 1'b0;
            s1_fdone_q <= 1'b0;
            s1_col_q   <= '0;
            s1_line_q  <= '0;
            bin_val    <= 1'b0;
            bin_dout   <= 1'b0;
            bin_href   <= 1'b0;
            bin_vsync  <= 1'b0;
            frame_done <= 1'b0;
            col_cnt    <= '0;
            line_cnt   <= '0;
        end else begin
            s1_val_q   <= accept;
            s1_dout_q  <= fg_d;
            s1_href_q  <= cam_href;
            s1_vsync_q <= cam_vsync;
            s1_fdone_q <= fdone_d;
            s1_col_q   <= col_q;
            s1_line_q  <= line_q;
            bin_val    <= s1_val_q;
            bin_dout   <= s1_dout_q;
            bin_href   <= s1_href_q;
            bin_vsync  <= s1_vsync_q;
            frame_done <= s1_fdone_q;
            col_cnt    <= s1_col_q;
            line_cnt   <= s1_line_q;
        end
    end

endmodule

// File: tb/tb_gray_binarize.sv
// Self-checking bench for gray_binarize: randomized frames scored against a line/frame-level model.
module tb_gray_binarize;

    localparam int unsigned MAXC = 4;
    localparam int LOGN = 16384;

    logic        module_clk   = 1'b0;
    logic        module_rst_n = 1'b1;
    logic        cam_href     = 1'b0;
    logic        cam_vsync    = 1'b0;
    logic        pix_val      = 1'b0;
    logic [7:0]  pix_data     = '0;
    logic [7:0]  thr          = 8'd128;
    logic        inv          = 1'b0;
    logic        bin_val, bin_dout, bin_href, bin_vsync, frame_done;
    logic [11:0] col_cnt, line_cnt;

    gray_binarize #(.MAX_COLS(MAXC)) dut (
        .module_clk  (module_clk),
        .module_rst_n(module_rst_n),
        .cam_href    (cam_href),
        .cam_vsync   (cam_vsync),
        .pix_val     (pix_val),
        .pix_data    (pix_data),
        .thr         (thr),
        .inv         (inv),
        .bin_val     (bin_val),
        .bin_dout    (bin_dout),
        .bin_href    (bin_href),
        .bin_vsync   (bin_vsync),
        .col_cnt     (col_cnt),
        .line_cnt    (line_cnt),
        .frame_done  (frame_done)
    );

    always #5 module_clk = ~module_clk;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    // Output vector layout: {frame_done, bin_vsync, bin_href, bin_val, bin_dout, line_cnt, col_cnt}
    logic [28:0] log_v [LOGN];
    bit   [28:0] exp_v [LOGN];
    bit   [28:0] msk_v [LOGN];

    always @(posedge module_clk) cyc <= cyc + 1;
    always @(negedge module_clk)
        if (cyc < LOGN) log_v[cyc] <= {frame_done, bin_vsync, bin_href, bin_val, bin_dout, line_cnt, col_cnt};

    int m_line;
    int m_thr;
    bit m_active;
`ifdef BIN_AUTO_THR_EN
    bit m_first;
    int m_min;
    int m_max;
`endif
    int lp [8];

    initial begin
        #1_000_000;
        $display("FAIL watchdog time=%0t limit=1000000", $time);
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_active = 1'b0;
        m_line   = 0;
`ifdef BIN_AUTO_THR_EN
        m_first = 1'b1;
        m_min   = 255;
        m_max   = 0;
`endif
    endtask

    task automatic model_frame(output bit fd);
        fd = m_active && (m_line != 0);
`ifdef BIN_AUTO_THR_EN
        m_thr   = m_first ? int'(thr) : (m_min + m_max) / 2;
        m_first = 1'b0;
        m_min   = 255;
        m_max   = 0;
`else
        m_thr = int'(thr);
`endif
        m_active = 1'b1;
        m_line   = 0;
    endtask

    // One input cycle; the outputs it causes are expected two cycles later.
    task automatic drive(input bit hr, input bit vs, input bit pv, input int pd,
                         input bit fd, input bit val, input bit dout, input int line, input int col,
                         input bit chk_pix, input bit chk_line);
        int t;
        t = cyc + 2;
        cam_href  = hr;
        cam_vsync = vs;
        pix_val   = pv;
        pix_data  = 8'(pd);
        if (t >= LOGN) begin
            $display("FAIL log_overflow cyc=%0d limit=%0d", t, LOGN);
            $fatal(1, "log overflow");
        end
        exp_v[t] = {fd, vs, hr, val, dout, 12'(line), 12'(col)};
        msk_v[t] = {4'hF, chk_pix, {12{chk_line}}, {12{chk_pix}}};
        @(negedge module_clk);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic frame_start();
        bit fd;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_frame(fd);
        drive(0, 1, 0, 0, fd, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic send_line(input int n, input bit with_vs, input int gap_pct, input int nidle);
        bit fd;
        bit any;
        bit acc;
        bit fg;
        int col;
        fd  = 1'b0;
        any = 1'b0;
        col = 0;
        if (with_vs) model_frame(fd);
        drive(1, with_vs, 0, 0, fd, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < n; k++) begin
            if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct)
                drive(1, 0, 0, 0, 0, 0, 0, m_line, 0, 0, 1);
            acc = m_active && (col < int'(MAXC));
            fg  = inv ? (lp[k] <= m_thr) : (lp[k] > m_thr);
            drive(1, 0, 1, lp[k], 0, acc, acc && fg, m_line, col, acc, 1);
            if (acc) begin
                col++;
                any = 1'b1;
`ifdef BIN_AUTO_THR_EN
                if (lp[k] < m_min) m_min = lp[k];
                if (lp[k] > m_max) m_max = lp[k];
`endif
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0, m_line, 0, 0, 1);
        if (any && m_line < 4095) m_line++;
        for (int i = 0; i < nidle; i++)
            drive(0, 0, ($urandom_range(3) == 0), int'($urandom_range(255)), 0, 0, 0, m_line, 0, 0, 1);
    endtask

    task automatic test_reset();
        int t0;
        #2 module_rst_n = 1'b0;
        #1;
        tests++;
        if ({frame_done, bin_vsync, bin_href, bin_val, bin_dout, line_cnt, col_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_assert got=%h exp=0", {frame_done, bin_vsync, bin_href, bin_val, bin_dout, line_cnt, col_cnt});
        end
        cam_href  = 1'b1;
        cam_vsync = 1'b1;
        pix_val   = 1'b1;
        pix_data  = 8'd255;
        repeat (3) @(negedge module_clk);
        tests++;
        if ({frame_done, bin_vsync, bin_href, bin_val, bin_dout, line_cnt, col_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_hold got=%h exp=0", {frame_done, bin_vsync, bin_href, bin_val, bin_dout, line_cnt, col_cnt});
        end
        module_rst_n = 1'b1;
        model_reset();
        t0 = cyc;
        drive(1, 1, 1, 200, 0, 0, 0, 0, 0, 0, 1);
        lp = '{10, 200, 128, 129, 0, 0, 0, 0};
        send_line(4, 0, 0, 2);
        idle(2);
        for (int c = t0; c < cyc; c++) if (msk_v[c] != '0) begin
            tests++;
            if ((log_v[c] & msk_v[c]) !== (exp_v[c] & msk_v[c])) begin
                fails++;
                $display("FAIL no_vsync cyc=%0d got=%h exp=%h mask=%h", c, log_v[c], exp_v[c], msk_v[c]);
            end
        end
    endtask

    task automatic test_basic();
        int t0;
        t0  = cyc;
        thr = 8'd128;
        inv = 1'b0;
        frame_start();
        lp = '{10, 200, 128, 129, 0, 0, 0, 0};
        send_line(4, 0, 0, 2);
        inv = 1'b1;
        send_line(4, 0, 0, 2);
        inv = 1'b0;
        idle(2);
        for (int c = t0; c < cyc; c++) if (msk_v[c] != '0) begin
            tests++;
            if ((log_v[c] & msk_v[c]) !== (exp_v[c] & msk_v[c])) begin
                fails++;
                $display("FAIL basic cyc=%0d got=%h exp=%h mask=%h", c, log_v[c], exp_v[c], msk_v[c]);
            end
        end
    endtask

    task automatic test_max_cols();
        int t0;
        t0 = cyc;
        frame_start();
        lp = '{250, 5, 250, 5, 250, 250, 0, 0};
        send_line(6, 0, 0, 3);
        idle(2);
        for (int c = t0; c < cyc; c++) if (msk_v[c] != '0) begin
            tests++;
            if ((log_v[c] & msk_v[c]) !== (exp_v[c] & msk_v[c])) begin
                fails++;
                $display("FAIL max_cols cyc=%0d got=%h exp=%h mask=%h", c, log_v[c], exp_v[c], msk_v[c]);
            end
        end
    endtask

    task automatic test_frame_done_thr();
        int t0;
        t0  = cyc;
        thr = 8'd128;
        frame_start();
        lp = '{60, 100, 140, 30, 0, 0, 0, 0};
        send_line(4, 0, 0, 1);
        thr = 8'd50;
        send_line(4, 0, 20, 1);
        send_line(4, 0, 0, 2);
        frame_start();
        send_line(4, 0, 0, 2);
        idle(2);
        for (int c = t0; c < cyc; c++) if (msk_v[c] != '0) begin
            tests++;
            if ((log_v[c] & msk_v[c]) !== (exp_v[c] & msk_v[c])) begin
                fails++;
                $display("FAIL frame_done_thr cyc=%0d got=%h exp=%h mask=%h", c, log_v[c], exp_v[c], msk_v[c]);
            end
        end
    endtask

    task automatic test_same_edge();
        int t0;
        t0 = cyc;
        idle(1);
        lp = '{49, 51, 200, 0, 0, 0, 0, 0};
        send_line(3, 1, 0, 2);
        send_line(2, 0, 0, 2);
        idle(2);
        for (int c = t0; c < cyc; c++) if (msk_v[c] != '0) begin
            tests++;
            if ((log_v[c] & msk_v[c]) !== (exp_v[c] & msk_v[c])) begin
                fails++;
                $display("FAIL same_edge cyc=%0d got=%h exp=%h mask=%h", c, log_v[c], exp_v[c], msk_v[c]);
            end
        end
    endtask

    task automatic test_reset_midline();
        int t0;
        t0 = cyc;
        frame_start();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 33, 0, 0, 0, 0, 0, 0, 0);
        drive(1, 0, 1, 99, 0, 0, 0, 0, 0, 0, 0);
        for (int c = cyc; c < cyc + 3; c++) msk_v[c] = '0;
        module_rst_n = 1'b0;
        #1;
        tests++;
        if ({frame_done, bin_vsync, bin_href, bin_val, bin_dout, line_cnt, col_cnt} !== '0) begin
            fails++;
            $display("FAIL reset_midline got=%h exp=0", {frame_done, bin_vsync, bin_href, bin_val, bin_dout, line_cnt, col_cnt});
        end
        repeat (2) @(negedge module_clk);
        module_rst_n = 1'b1;
        model_reset();
        lp = '{200, 201, 202, 10, 0, 0, 0, 0};
        send_line(3, 0, 0, 2);
        frame_start();
        send_line(4, 0, 0, 2);
        idle(2);
        for (int c = t0; c < cyc; c++) if (msk_v[c] != '0) begin
            tests++;
            if ((log_v[c] & msk_v[c]) !== (exp_v[c] & msk_v[c])) begin
                fails++;
                $display("FAIL reset_midline_seq cyc=%0d got=%h exp=%h mask=%h", c, log_v[c], exp_v[c], msk_v[c]);
            end
        end
    endtask

    task automatic test_random();
        int t0;
        int nl;
        bit vs_first;
        t0 = cyc;
        for (int f = 0; f < 6; f++) begin
            thr      = 8'($urandom_range(255));
            inv      = 1'($urandom_range(1));
            nl       = int'($urandom_range(1, 4));
            vs_first = 1'($urandom_range(1));
            if (!vs_first) frame_start();
            for (int l = 0; l < nl; l++) begin
                for (int i = 0; i < 8; i++) lp[i] = int'($urandom_range(255));
                send_line(int'($urandom_range(0, 6)), vs_first && (l == 0), 30, int'($urandom_range(1, 3)));
            end
        end
        inv = 1'b0;
        idle(2);
        for (int c = t0; c < cyc; c++) if (msk_v[c] != '0) begin
            tests++;
            if ((log_v[c] & msk_v[c]) !== (exp_v[c] & msk_v[c])) begin
                fails++;
                $display("FAIL random cyc=%0d got=%h exp=%h mask=%h", c, log_v[c], exp_v[c], msk_v[c]);
            end
        end
    endtask

    task automatic test_line_saturation();
        int t0;
        t0  = cyc;
        thr = 8'd100;
        frame_start();
        lp[0] = 177;
        for (int l = 0; l < 4100; l++) send_line(1, 0, 0, 0);
        idle(2);
        frame_start();
        idle(2);
        for (int c = t0; c < cyc; c++) if (msk_v[c] != '0) begin
            tests++;
            if ((log_v[c] & msk_v[c]) !== (exp_v[c] & msk_v[c])) begin
                fails++;
                $display("FAIL line_saturation cyc=%0d got=%h exp=%h mask=%h", c, log_v[c], exp_v[c], msk_v[c]);
            end
        end
    endtask

`ifdef BIN_AUTO_THR_EN
    task automatic test_auto_thr();
        int t0;
        t0  = cyc;
        inv = 1'b0;
        thr = 8'd7;
        frame_start();
        lp = '{40, 200, 100, 150, 0, 0, 0, 0};
        send_line(4, 0, 0, 2);
        frame_start();
        lp = '{120, 121, 0, 255, 0, 0, 0, 0};
        send_line(4, 0, 0, 2);
        idle(2);
        for (int c = t0; c < cyc; c++) if (msk_v[c] != '0) begin
            tests++;
            if ((log_v[c] & msk_v[c]) !== (exp_v[c] & msk_v[c])) begin
                fails++;
                $display("FAIL auto_thr cyc=%0d got=%h exp=%h mask=%h", c, log_v[c], exp_v[c], msk_v[c]);
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_max_cols();
        test_frame_done_thr();
        test_same_edge();
        test_reset_midline();
        test_random();
        test_line_saturation();
`ifdef BIN_AUTO_THR_EN
        test_auto_thr();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
